multicycle_control: RTL and testbench

- Parametrised multi-cycle MIPS control unit, the sequential successor to the single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath enables per state.
- Supports wait-state memory via a ready handshake, an iterative mult/div stall, and an illegal-opcode trap.
- Sits between the instruction register (OpCode/Funct) and the shared-memory multi-cycle datapath.

---
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/multicycle_control.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Handshake/control bundle between the multi-cycle control unit and its datapath.
// The master side is the control unit; the slave side is the datapath/memory.
interface multicycle_control_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       ExtOp;
  logic       LuOp;
  logic       MulDivStart;
  logic       Busy;
  logic       IllegalOp;
  logic [2:0] State;

  modport master (
    input  OpCode, Funct, Zero, MemReady,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           ExtOp, LuOp, MulDivStart, Busy, IllegalOp, State
  );

  modport slave (
    output OpCode, Funct, Zero, MemReady,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           ExtOp, LuOp, MulDivStart, Busy, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB plus an iterative
// mult/div stall state and an illegal-instruction trap, with wait-state memory.
module multicycle_control #(
  parameter bit          MEM_HANDSHAKE  = 1'b1,
  parameter bit          ENABLE_MULDIV  = 1'b1,
  parameter int unsigned MULDIV_CYCLES  = 32,
  parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULDIV = 3'd5,
    S_EXCEPT = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV  = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08, F_JALR  = 6'h09, F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12, F_MULT  = 6'h18, F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV  = 6'h1A, F_DIVU  = 6'h1B, F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUB   = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR    = 6'h25, F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27, F_SLT   = 6'h2A, F_SLTU = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3, ALU_OR  = 3'd4, ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6, ALU_LUI = 3'd7;

  localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] mdCount_q, mdCount_d;

  logic       isShift, isRAlu, isJr, isJalr, isMulDiv, isMfHiLo;
  logic       isImm, isLw, isSw, isBranch, isJ, isJal, isLegal;
  logic [2:0] immAluOp;
  logic       memReady;

  assign memReady = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

  always_comb begin
    isShift  = 1'b0;
    isRAlu   = 1'b0;
    isJr     = 1'b0;
    isJalr   = 1'b0;
    isMulDiv = 1'b0;
    isMfHiLo = 1'b0;
    isImm    = 1'b0;
    isLw     = 1'b0;
    isSw     = 1'b0;
    isBranch = 1'b0;
    isJ      = 1'b0;
    isJal    = 1'b0;
    immAluOp = ALU_ADD;
    case (bus.OpCode)
      OP_RTYPE: begin
        case (bus.Funct)
          F_SLL, F_SRL, F_SRA: isShift = 1'b1;
          F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: isRAlu = 1'b1;
          F_JR:                                   isJr = 1'b1;
          F_JALR:                                 isJalr = 1'b1;
          F_MFHI, F_MFLO:                         isMfHiLo = ENABLE_MULDIV;
          F_MULT, F_MULTU, F_DIV, F_DIVU:         isMulDiv = ENABLE_MULDIV;
          default: ;
        endcase
      end
      OP_J:             isJ = 1'b1;
      OP_JAL:           isJal = 1'b1;
      OP_BEQ, OP_BNE:   isBranch = 1'b1;
      OP_ADDI, OP_ADDIU: isImm = 1'b1;
      OP_SLTI:  begin isImm = 1'b1; immAluOp = ALU_SLT;  end
      OP_SLTIU: begin isImm = 1'b1; immAluOp = ALU_SLTU; end
      OP_ANDI:  begin isImm = 1'b1; immAluOp = ALU_AND;  end
      OP_ORI:   begin isImm = 1'b1; immAluOp = ALU_OR;   end
      OP_LUI:   begin isImm = 1'b1; immAluOp = ALU_LUI;  end
      OP_LW:            isLw = 1'b1;
      OP_SW:            isSw = 1'b1;
      default: ;
    endcase
  end

  assign isLegal = isShift | isRAlu | isJr | isJalr | isMulDiv | isMfHiLo |
                   isImm | isLw | isSw | isBranch | isJ | isJal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      mdCount_q <= '0;
    end else begin
      state_q   <= state_d;
      mdCount_q <= mdCount_d;
    end
  end

  // Outputs are forced low whenever reset is held, independent of the clock.
  always_comb begin
    state_d         = state_q;
    mdCount_d       = mdCount_q;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchNe    = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 2'd0;
    bus.MemtoReg    = 2'd0;
    bus.ALUSrcA     = 2'd0;
    bus.ALUSrcB     = 2'd0;
    bus.ALUOp       = ALU_ADD;
    bus.PCSource    = 2'd0;
    bus.ExtOp       = 1'b0;
    bus.LuOp        = 1'b0;
    bus.MulDivStart = 1'b0;
    bus.Busy        = 1'b0;
    bus.IllegalOp   = 1'b0;
    bus.State       = state_q;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'd1;
          if (memReady) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            state_d     = S_DECODE;
          end
        end
        S_DECODE: begin
          // Branch target is precomputed here, so the offset is sign-extended.
          bus.ALUSrcB = 2'd3;
          bus.ExtOp   = 1'b1;
          if (isJ || isJal) begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'd2;
            if (isJal) begin
              bus.RegWrite = 1'b1;
              bus.RegDst   = 2'd2;
              bus.MemtoReg = 2'd2;
            end
            state_d = S_FETCH;
          end else if (!isLegal) begin
            state_d = S_EXCEPT;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          state_d = S_FETCH;
          if (isShift || isRAlu) begin
            bus.ALUSrcA = isShift ? 2'd2 : 2'd1;
            bus.ALUOp   = ALU_FUNCT;
            state_d     = S_WB;
          end else if (isImm) begin
            bus.ALUSrcA = 2'd1;
            bus.ALUSrcB = 2'd2;
            bus.ALUOp   = immAluOp;
            bus.ExtOp   = !(bus.OpCode == OP_ANDI || bus.OpCode == OP_ORI ||
                            bus.OpCode == OP_LUI);
            bus.LuOp    = (bus.OpCode == OP_LUI);
            state_d     = S_WB;
          end else if (isLw || isSw) begin
            bus.ALUSrcA = 2'd1;
            bus.ALUSrcB = 2'd2;
            bus.ExtOp   = 1'b1;
            state_d     = S_MEM;
          end else if (isBranch) begin
            bus.ALUSrcA     = 2'd1;
            bus.ALUOp       = ALU_SUB;
            bus.PCWriteCond = 1'b1;
            bus.BranchNe    = (bus.OpCode == OP_BNE);
            bus.PCSource    = 2'd1;
          end else if (isJr || isJalr) begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'd3;
            if (isJalr) begin
              bus.RegWrite = 1'b1;
              bus.RegDst   = 2'd1;
              bus.MemtoReg = 2'd2;
            end
          end else if (isMulDiv) begin
            bus.MulDivStart = 1'b1;
            mdCount_d       = MD_LOAD;
            state_d         = S_MULDIV;
          end else if (isMfHiLo) begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          bus.IorD     = 1'b1;
          bus.MemRead  = isLw;
          bus.MemWrite = isSw;
          if (memReady) begin
            state_d = isLw ? S_WB : S_FETCH;
          end
        end
        S_WB: begin
          bus.RegWrite = 1'b1;
          if (isLw) begin
            bus.MemtoReg = 2'd1;
          end else if (isShift || isRAlu || isMfHiLo) begin
            bus.RegDst   = 2'd1;
            bus.MemtoReg = isMfHiLo ? 2'd3 : 2'd0;
          end
          state_d = S_FETCH;
        end
        S_MULDIV: begin
          bus.Busy = 1'b1;
          if (mdCount_q == 8'd0) begin
            state_d = S_FETCH;
          end else begin
            mdCount_d = mdCount_q - 8'd1;
          end
        end
        S_EXCEPT: begin
          bus.IllegalOp = 1'b1;
          bus.PCWrite   = 1'b1;
          bus.PCSource  = EXC_VECTOR_SEL;
          state_d       = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-instruction phase model builds the expected
// cycle-by-cycle control words, and a negedge process compares both DUTs to it.
`timescale 1ns/1ps
module tb_multicycle_control;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNe;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       ExtOp;
    logic       LuOp;
    logic       MulDivStart;
    logic       Busy;
    logic       IllegalOp;
    logic [2:0] State;
  } ctrl_t;

  typedef struct packed {
    logic  ready;
    ctrl_t exp;
  } step_t;

  typedef enum logic [3:0] {
    C_SHIFT, C_RALU, C_IMM, C_LW, C_SW, C_BR, C_J, C_JAL,
    C_JR, C_JALR, C_MULDIV, C_MFHILO, C_ILL
  } cls_e;

  localparam int A_CYCLES = 4;
  localparam int B_CYCLES = 32;

  logic clk = 1'b0;
  logic resetA, resetB;
  always #5 clk = ~clk;

  multicycle_control_if ifA();
  multicycle_control_if ifB();

  multicycle_control #(
    .MEM_HANDSHAKE(1'b1), .ENABLE_MULDIV(1'b1),
    .MULDIV_CYCLES(A_CYCLES), .EXC_VECTOR_SEL(2'b11)
  ) dutA (.clk(clk), .reset(resetA), .bus(ifA));

  multicycle_control #(
    .MEM_HANDSHAKE(1'b0), .ENABLE_MULDIV(1'b0),
    .MULDIV_CYCLES(B_CYCLES), .EXC_VECTOR_SEL(2'b11)
  ) dutB (.clk(clk), .reset(resetB), .bus(ifB));

  ctrl_t obsA, obsB;
  assign obsA = {ifA.PCWrite, ifA.PCWriteCond, ifA.BranchNe, ifA.IorD, ifA.MemRead,
                 ifA.MemWrite, ifA.IRWrite, ifA.RegWrite, ifA.RegDst, ifA.MemtoReg,
                 ifA.ALUSrcA, ifA.ALUSrcB, ifA.ALUOp, ifA.PCSource, ifA.ExtOp,
                 ifA.LuOp, ifA.MulDivStart, ifA.Busy, ifA.IllegalOp, ifA.State};
  assign obsB = {ifB.PCWrite, ifB.PCWriteCond, ifB.BranchNe, ifB.IorD, ifB.MemRead,
                 ifB.MemWrite, ifB.IRWrite, ifB.RegWrite, ifB.RegDst, ifB.MemtoReg,
                 ifB.ALUSrcA, ifB.ALUSrcB, ifB.ALUOp, ifB.PCSource, ifB.ExtOp,
                 ifB.LuOp, ifB.MulDivStart, ifB.Busy, ifB.IllegalOp, ifB.State};

  int    checks = 0;
  int    errors = 0;
  step_t trace[$];
  ctrl_t expNow = '0;
  bit    expValid = 1'b0;
  bit    sel = 1'b0;
  int    cyc = 0;
  string tag = "reset";
  int    pulseIrw = 0, pulseBusy = 0, pulseIll = 0, pulseMds = 0;
  ctrl_t got, idle;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, required);
    end
  endtask

  function automatic cls_e classify(input bit mdEn, input logic [5:0] op,
                                    input logic [5:0] fn);
    cls_e k;
    k = C_ILL;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03: k = C_SHIFT;
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
          6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: k = C_RALU;
          6'h08: k = C_JR;
          6'h09: k = C_JALR;
          6'h10, 6'h12: if (mdEn) k = C_MFHILO;
          6'h18, 6'h19, 6'h1A, 6'h1B: if (mdEn) k = C_MULDIV;
          default: ;
        endcase
      end
      6'h02: k = C_J;
      6'h03: k = C_JAL;
      6'h04, 6'h05: k = C_BR;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F: k = C_IMM;
      6'h23: k = C_LW;
      6'h2B: k = C_SW;
      default: ;
    endcase
    return k;
  endfunction

  function automatic logic [2:0] immAluOp(input logic [5:0] op);
    case (op)
      6'h0A:   return 3'd5;
      6'h0B:   return 3'd6;
      6'h0C:   return 3'd3;
      6'h0D:   return 3'd4;
      6'h0F:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic ctrl_t base(input logic [2:0] st);
    ctrl_t c;
    c = '0;
    c.State = st;
    return c;
  endfunction

  function automatic void pushStep(input logic rdy, input ctrl_t c);
    step_t s;
    s.ready = rdy;
    s.exp   = c;
    trace.push_back(s);
  endfunction

  // Expected trace for one instruction: fw/mw are not-ready cycles in FETCH/MEM.
  function automatic void buildTrace(input bit cfgB, input logic [5:0] op,
                                     input logic [5:0] fn, input int fw, input int mw);
    cls_e  k;
    ctrl_t c;
    logic  hs;
    int    nMd;
    hs  = !cfgB;
    nMd = cfgB ? B_CYCLES : A_CYCLES;
    k   = classify(!cfgB, op, fn);
    trace.delete();
    c = base(3'd0);
    c.MemRead = 1'b1;
    c.ALUSrcB = 2'd1;
    if (hs) for (int i = 0; i < fw; i++) pushStep(1'b0, c);
    c.IRWrite = 1'b1;
    c.PCWrite = 1'b1;
    pushStep(hs, c);
    c = base(3'd1);
    c.ALUSrcB = 2'd3;
    c.ExtOp   = 1'b1;
    if (k == C_J || k == C_JAL) begin
      c.PCWrite  = 1'b1;
      c.PCSource = 2'd2;
      if (k == C_JAL) begin
        c.RegWrite = 1'b1;
        c.RegDst   = 2'd2;
        c.MemtoReg = 2'd2;
      end
      pushStep(hs, c);
      return;
    end
    pushStep(hs, c);
    if (k == C_ILL) begin
      c = base(3'd6);
      c.IllegalOp = 1'b1;
      c.PCWrite   = 1'b1;
      c.PCSource  = 2'b11;
      pushStep(hs, c);
      return;
    end
    c = base(3'd2);
    case (k)
      C_SHIFT, C_RALU: begin
        c.ALUSrcA = (k == C_SHIFT) ? 2'd2 : 2'd1;
        c.ALUOp   = 3'd2;
      end
      C_IMM: begin
        c.ALUSrcA = 2'd1;
        c.ALUSrcB = 2'd2;
        c.ALUOp   = immAluOp(op);
        c.ExtOp   = !(op == 6'h0C || op == 6'h0D || op == 6'h0F);
        c.LuOp    = (op == 6'h0F);
      end
      C_LW, C_SW: begin
        c.ALUSrcA = 2'd1;
        c.ALUSrcB = 2'd2;
        c.ExtOp   = 1'b1;
      end
      C_BR: begin
        c.ALUSrcA     = 2'd1;
        c.ALUOp       = 3'd1;
        c.PCWriteCond = 1'b1;
        c.BranchNe    = (op == 6'h05);
        c.PCSource    = 2'd1;
      end
      C_JR, C_JALR: begin
        c.PCWrite  = 1'b1;
        c.PCSource = 2'd3;
        if (k == C_JALR) begin
          c.RegWrite = 1'b1;
          c.RegDst   = 2'd1;
          c.MemtoReg = 2'd2;
        end
      end
      C_MULDIV: c.MulDivStart = 1'b1;
      default: ;
    endcase
    pushStep(hs, c);
    if (k == C_BR || k == C_JR || k == C_JALR) return;
    if (k == C_MULDIV) begin
      c = base(3'd5);
      c.Busy = 1'b1;
      for (int i = 0; i < nMd; i++) pushStep(hs, c);
      return;
    end
    if (k == C_LW || k == C_SW) begin
      c = base(3'd3);
      c.IorD     = 1'b1;
      c.MemRead  = (k == C_LW);
      c.MemWrite = (k == C_SW);
      if (hs) for (int i = 0; i < mw; i++) pushStep(1'b0, c);
      pushStep(hs, c);
      if (k == C_SW) return;
    end
    c = base(3'd4);
    c.RegWrite = 1'b1;
    if (k == C_LW) begin
      c.MemtoReg = 2'd1;
    end else if (k != C_IMM) begin
      c.RegDst   = 2'd1;
      c.MemtoReg = (k == C_MFHILO) ? 2'd3 : 2'd0;
    end
    pushStep(hs, c);
  endfunction

  always @(negedge clk) begin
    if (expValid) begin
      got  = sel ? obsB : obsA;
      idle = sel ? obsA : obsB;
      checkOutput($sformatf("%s step%0d dut%s", tag, cyc, sel ? "B" : "A"),
                  32'(got), 32'(expNow));
      checkOutput($sformatf("%s step%0d idle dut held in reset", tag, cyc),
                  32'(idle), 32'd0);
      if (got.IRWrite)     pulseIrw++;
      if (got.Busy)        pulseBusy++;
      if (got.IllegalOp)   pulseIll++;
      if (got.MulDivStart) pulseMds++;
    end
  end

  task automatic setInstr(input bit s, input logic [5:0] op, input logic [5:0] fn);
    if (!s) begin
      ifA.OpCode = op;
      ifA.Funct  = fn;
    end else begin
      ifB.OpCode = op;
      ifB.Funct  = fn;
    end
  endtask

  task automatic runStep(input bit s, input step_t st, input int idx);
    if (!s) ifA.MemReady = st.ready;
    else    ifB.MemReady = st.ready;
    expNow   = st.exp;
    cyc      = idx;
    expValid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit s, input logic [5:0] op, input logic [5:0] fn,
                               input int fw, input int mw, input int expLen,
                               input string name);
    buildTrace(s, op, fn, fw, mw);
    checkOutput({name, " latency"}, 32'(trace.size()), 32'(expLen));
    tag       = name;
    sel       = s;
    pulseIrw  = 0;
    pulseBusy = 0;
    pulseIll  = 0;
    pulseMds  = 0;
    setInstr(s, op, fn);
    foreach (trace[i]) runStep(s, trace[i], i);
  endtask

  initial begin
    resetA = 1'b0;
    resetB = 1'b0;
    setInstr(1'b0, 6'h00, 6'h00);
    setInstr(1'b1, 6'h00, 6'h00);
    ifA.Zero = 1'b0;
    ifB.Zero = 1'b0;
    ifA.MemReady = 1'b1;
    ifB.MemReady = 1'b0;
    #2;
    checkOutput("reset outputs dutA", 32'(obsA), 32'd0);
    checkOutput("reset outputs dutB", 32'(obsB), 32'd0);
    @(posedge clk);
    #1;
    resetA = 1'b1;

    applyStimulus(1'b0, 6'h00, 6'h20, 0, 0, 4, "add");
    applyStimulus(1'b0, 6'h23, 6'h00, 2, 3, 10, "lw_wait");
    checkOutput("lw IRWrite pulses", 32'(pulseIrw), 32'd1);
    applyStimulus(1'b0, 6'h05, 6'h00, 0, 0, 3, "bne");
    applyStimulus(1'b0, 6'h00, 6'h18, 0, 0, 7, "mult");
    checkOutput("mult Busy cycles", 32'(pulseBusy), 32'd4);
    checkOutput("mult MulDivStart pulses", 32'(pulseMds), 32'd1);
    applyStimulus(1'b0, 6'h3F, 6'h00, 0, 0, 3, "op3f");
    checkOutput("op3f IllegalOp pulses", 32'(pulseIll), 32'd1);
    applyStimulus(1'b0, 6'h2B, 6'h00, 0, 1, 5, "sw_wait");
    applyStimulus(1'b0, 6'h03, 6'h00, 0, 0, 2, "jal");
    applyStimulus(1'b0, 6'h00, 6'h09, 0, 0, 3, "jalr");
    applyStimulus(1'b0, 6'h00, 6'h00, 1, 0, 5, "sll");
    applyStimulus(1'b0, 6'h0F, 6'h00, 0, 0, 4, "lui");
    applyStimulus(1'b0, 6'h0D, 6'h00, 0, 0, 4, "ori");
    applyStimulus(1'b0, 6'h0A, 6'h00, 0, 0, 4, "slti");
    applyStimulus(1'b0, 6'h04, 6'h00, 0, 0, 3, "beq");
    applyStimulus(1'b0, 6'h02, 6'h00, 0, 0, 2, "j");
    applyStimulus(1'b0, 6'h00, 6'h10, 0, 0, 4, "mfhi");
    applyStimulus(1'b0, 6'h0E, 6'h00, 0, 0, 3, "xori");
    applyStimulus(1'b0, 6'h00, 6'h01, 0, 0, 3, "funct01");
    applyStimulus(1'b0, 6'h00, 6'h1B, 0, 0, 7, "divu");

    // Reset in the middle of the mult/div stall must drop everything at once.
    buildTrace(1'b0, 6'h00, 6'h18, 0, 0);
    tag = "rst_muldiv";
    setInstr(1'b0, 6'h00, 6'h18);
    for (int i = 0; i < 4; i++) runStep(1'b0, trace[i], i);
    expValid = 1'b0;
    #2;
    checkOutput("busy before reset", 32'(obsA.Busy), 32'd1);
    resetA = 1'b0;
    #1;
    checkOutput("async reset drop", 32'(obsA), 32'd0);
    expNow   = '0;
    expValid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetA = 1'b1;
    #1;
    checkOutput("state after release", 32'(obsA.State), 32'd0);
    checkOutput("busy after release", 32'(obsA.Busy), 32'd0);
    applyStimulus(1'b0, 6'h00, 6'h20, 0, 0, 4, "add_after_rst");
    applyStimulus(1'b0, 6'h00, 6'h1A, 0, 0, 7, "div_after_rst");
    checkOutput("div Busy cycles", 32'(pulseBusy), 32'd4);

    resetA = 1'b0;
    resetB = 1'b1;
    applyStimulus(1'b1, 6'h00, 6'h18, 0, 0, 3, "mult_disabled");
    checkOutput("mult_disabled IllegalOp pulses", 32'(pulseIll), 32'd1);
    applyStimulus(1'b1, 6'h00, 6'h12, 0, 0, 3, "mflo_disabled");
    applyStimulus(1'b1, 6'h23, 6'h00, 2, 3, 5, "lw_nohs");
    applyStimulus(1'b1, 6'h2B, 6'h00, 0, 2, 4, "sw_nohs");
    applyStimulus(1'b1, 6'h00, 6'h22, 0, 0, 4, "sub_nohs");
    applyStimulus(1'b1, 6'h09, 6'h00, 0, 0, 4, "addiu_nohs");
    expValid = 1'b0;
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
